// File: rtl/axis_pkg.sv
// Shared constants, state encoding and width helpers for the AXI read-burst controller.
package axis_pkg;

    localparam int unsigned AXI_4K_BYTES  = 4096;
    localparam int unsigned AXI_LEN_WIDTH = 8;

    localparam int unsigned IDLE_IDX  = 0;
    localparam int unsigned START_IDX = 1;
    localparam int unsigned ADDR_IDX  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'(1 << IDLE_IDX),
        START = 3'(1 << START_IDX),
        ADDR  = 3'(1 << ADDR_IDX)
    } state_t;

    function automatic int unsigned axi_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned axi_addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axis_burst_calc.sv
// Registered burst size: min(remaining, BURST_MAX, beats left before the next 4 KB boundary).
module axis_burst_calc
    import axis_pkg::*;
#(
    parameter int unsigned CFG_DWIDTH = 32,
    parameter int unsigned BURST_MAX  = 16,
    parameter int unsigned ADDR_LSB   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [CFG_DWIDTH-1:0]   remaining,
    input  logic [11:0]             addr_4k,
    output logic [AXI_LEN_WIDTH:0]  burst,
    output logic                    valid
);

    localparam int unsigned BW = AXI_LEN_WIDTH + 1;

    logic [12:0]   bytes_to_4k;
    logic [12:0]   beats_to_4k;
    logic [BW-1:0] burst_next;

    always_comb begin
        bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_4k};
        beats_to_4k = bytes_to_4k >> ADDR_LSB;
        burst_next  = BW'(BURST_MAX);
        if (beats_to_4k < 13'(burst_next)) begin
            burst_next = BW'(beats_to_4k);
        end
        if (remaining < CFG_DWIDTH'(burst_next)) begin
            burst_next = BW'(remaining);
        end
    end

    // valid trails en by one cycle so the burst always reflects the current addr/remaining
    always_ff @(posedge clk) begin
        if (rst) begin
            burst <= '0;
            valid <= 1'b0;
        end else begin
            burst <= burst_next;
            valid <= en;
        end
    end

endmodule

// File: rtl/axis_read_burst_ctrl.sv
// Sequences one AXI read stream: config handshake to the data block, then credit-throttled,
// 4 KB-safe read-address bursts.
module axis_read_burst_ctrl
    import axis_pkg::*;
#(
    parameter int unsigned BUF_AWIDTH     = 9,
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned WIDTH_RATIO    = 2,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned BURST_MAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_DWIDTH-1:0]     cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [CFG_DWIDTH-1:0]     dat_length,
    output logic                      dat_valid,
    input  logic                      dat_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic                      axi_rbeat
);

    localparam int unsigned BYTES      = axi_bytes(AXI_DATA_WIDTH);
    localparam int unsigned ADDR_LSB   = axi_addr_lsb(AXI_DATA_WIDTH);
    localparam int unsigned CREDIT_MAX = 2 ** BUF_AWIDTH;
    localparam int unsigned OW         = BUF_AWIDTH + 1;
    localparam int unsigned BW         = AXI_LEN_WIDTH + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] LSB_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    state_t                    state;
    state_t                    state_next;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [CFG_DWIDTH-1:0]     remaining;
    logic [OW-1:0]             outstanding;
    logic [BW-1:0]             burst;
    logic                      burst_valid;
    logic                      calc_en;
    logic [31:0]               credit_need;
    logic                      credit_ok;
    logic                      cfg_hs;
    logic                      ar_hs;
    logic                      last_burst;

    axis_burst_calc #(
        .CFG_DWIDTH (CFG_DWIDTH),
        .BURST_MAX  (BURST_MAX),
        .ADDR_LSB   (ADDR_LSB)
    ) u_burst_calc (
        .clk       (clk),
        .rst       (rst),
        .en        (calc_en),
        .remaining (remaining),
        .addr_4k   (addr[11:0]),
        .burst     (burst),
        .valid     (burst_valid)
    );

    assign calc_en     = (state == ADDR) && !ar_hs;
    assign credit_need = 32'(outstanding) + 32'(burst);
    assign credit_ok   = credit_need <= 32'(CREDIT_MAX);
    assign cfg_hs      = cfg_valid && cfg_ready;
    assign ar_hs       = axi_arvalid && axi_arready;
    assign last_burst  = remaining == CFG_DWIDTH'(burst);
    assign axi_araddr  = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Credit only grows back while arvalid waits, so arvalid cannot drop before arready.
    always_comb begin
        state_next  = state;
        cfg_ready   = 1'b0;
        dat_valid   = 1'b0;
        dat_length  = '0;
        axi_arvalid = 1'b0;
        axi_arlen   = '0;
        unique case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid && cfg_length != '0) begin
                    state_next = START;
                end
            end
            START: begin
                dat_valid  = 1'b1;
                dat_length = remaining * CFG_DWIDTH'(WIDTH_RATIO);
                if (dat_ready) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                axi_arvalid = burst_valid && credit_ok;
                if (axi_arvalid) begin
                    axi_arlen = AXI_LEN_WIDTH'(burst - BW'(1));
                end
                if (axi_arvalid && axi_arready && last_burst) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
        end else if (cfg_hs) begin
            addr      <= AXI_ADDR_WIDTH'(cfg_address) & ~LSB_MASK;
            remaining <= cfg_length;
        end else if (ar_hs) begin
            addr      <= addr + (AXI_ADDR_WIDTH'(burst) << ADDR_LSB);
            remaining <= remaining - CFG_DWIDTH'(burst);
        end
    end

    // Keeps counting in IDLE so a following transfer sees credit still held by the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (ar_hs) begin
            outstanding <= outstanding + OW'(burst) - OW'(axi_rbeat);
        end else if (axi_rbeat && outstanding != '0) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    logic                      ar_wait;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_prev;
    logic [AXI_LEN_WIDTH-1:0]  ar_len_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_wait      <= 1'b0;
            ar_addr_prev <= '0;
            ar_len_prev  <= '0;
        end else begin
            ar_wait      <= axi_arvalid && !axi_arready;
            ar_addr_prev <= axi_araddr;
            ar_len_prev  <= axi_arlen;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(axi_rbeat && !ar_hs && outstanding == '0));
            assert (!ar_wait || (axi_arvalid && axi_araddr == ar_addr_prev
                                 && axi_arlen == ar_len_prev));
        end
    end

endmodule

// File: tb/tb_axis_read_burst_ctrl.sv
// Directed bench for axis_read_burst_ctrl: vector table of transfers plus hand-written corner sequences.
module tb_axis_read_burst_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] cfg_address, cfg_length, dat_length, axi_araddr;
    logic        cfg_valid, cfg_ready, dat_valid, dat_ready;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid, axi_arready, axi_rbeat;

    logic [31:0] c_cfg_address, c_cfg_length, c_dat_length, c_araddr;
    logic        c_cfg_valid, c_cfg_ready, c_dat_valid, c_dat_ready;
    logic [7:0]  c_arlen;
    logic        c_arvalid, c_arready, c_rbeat;

    int checks = 0;
    int errors = 0;

    axis_read_burst_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_address (cfg_address),
        .cfg_length  (cfg_length),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .dat_length  (dat_length),
        .dat_valid   (dat_valid),
        .dat_ready   (dat_ready),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rbeat   (axi_rbeat)
    );

    axis_read_burst_ctrl #(.BUF_AWIDTH(5)) dut_c (
        .clk         (clk),
        .rst         (rst),
        .cfg_address (c_cfg_address),
        .cfg_length  (c_cfg_length),
        .cfg_valid   (c_cfg_valid),
        .cfg_ready   (c_cfg_ready),
        .dat_length  (c_dat_length),
        .dat_valid   (c_dat_valid),
        .dat_ready   (c_dat_ready),
        .axi_araddr  (c_araddr),
        .axi_arlen   (c_arlen),
        .axi_arvalid (c_arvalid),
        .axi_arready (c_arready),
        .axi_rbeat   (c_rbeat)
    );

    // Inputs change at posedge+1, so a handshake seen at negedge completes on the next posedge.
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int          c_hs = 0;
    logic [31:0] c_last_addr = '0;
    logic [7:0]  c_last_len = '0;

    always @(negedge clk) begin
        if (!rst && axi_arvalid && axi_arready) begin
            ar_addr_q.push_back(axi_araddr);
            ar_len_q.push_back(axi_arlen);
        end
        if (!rst && c_arvalid && c_arready) begin
            c_hs++;
            c_last_addr = c_araddr;
            c_last_len  = c_arlen;
        end
    end

    typedef struct packed {
        logic [31:0]       addr;
        logic [31:0]       len;
        logic [31:0]       dlen;
        int                nb;
        logic [2:0][31:0]  ea;
        logic [2:0][7:0]   el;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] len,
                                input logic [31:0] dlen, input int nb,
                                input logic [31:0] a0, input logic [7:0] l0,
                                input logic [31:0] a1, input logic [7:0] l1,
                                input logic [31:0] a2, input logic [7:0] l2);
        vec_t v;
        v.addr = addr; v.len = len; v.dlen = dlen; v.nb = nb;
        v.ea[0] = a0; v.el[0] = l0;
        v.ea[1] = a1; v.el[1] = l1;
        v.ea[2] = a2; v.el[2] = l2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg(input logic [31:0] a, input logic [31:0] l);
        cfg_address = a;
        cfg_length  = l;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic wait_bursts(input int n);
        int k = 0;
        while (ar_addr_q.size() < n && k < 200) begin
            tick();
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        ar_addr_q.delete();
        ar_len_q.delete();
        axi_arready = 1'b1;
        start_cfg(v.addr, v.len);
        dat_ready = 1'b1;
        @(negedge clk);
        check("dat_valid", 32'(dat_valid), 1);
        check("dat_length", dat_length, v.dlen);
        tick();
        dat_ready = 1'b0;
        @(negedge clk);
        check("ar_bubble", 32'(axi_arvalid), 0);
        tick();
        @(negedge clk);
        check("ar_latency", 32'(axi_arvalid), 1);
        wait_bursts(v.nb);
        tick();
        @(negedge clk);
        check("burst_count", ar_addr_q.size(), v.nb);
        check("cfg_ready_after", 32'(cfg_ready), 1);
        for (int i = 0; i < v.nb && i < ar_addr_q.size(); i++) begin
            check($sformatf("araddr[%0d]", i), ar_addr_q[i], v.ea[i]);
            check($sformatf("arlen[%0d]", i), 32'(ar_len_q[i]), 32'(v.el[i]));
        end
        tick();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = mk(32'h1000, 40, 80, 3, 32'h1000, 15, 32'h1080, 15, 32'h1100, 7);
        vecs[1] = mk(32'h1FC0, 16, 32, 2, 32'h1FC0, 7, 32'h2000, 7, 0, 0);
        vecs[2] = mk(32'h1004, 3, 6, 1, 32'h1000, 2, 0, 0, 0, 0);
        vecs[3] = mk(32'h0FF8, 20, 40, 3, 32'h0FF8, 0, 32'h1000, 15, 32'h1080, 2);
        vecs[4] = mk(32'h2000, 1, 2, 1, 32'h2000, 0, 0, 0, 0, 0);

        rst = 1'b1;
        cfg_address = '0; cfg_length = '0; cfg_valid = 1'b0; dat_ready = 1'b0;
        axi_arready = 1'b1; axi_rbeat = 1'b0;
        c_cfg_address = '0; c_cfg_length = '0; c_cfg_valid = 1'b0; c_dat_ready = 1'b1;
        c_arready = 1'b1; c_rbeat = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 1);
        check("rst_dat_valid", 32'(dat_valid), 0);
        check("rst_arvalid", 32'(axi_arvalid), 0);
        check("rst_araddr", axi_araddr, 0);
        check("rst_arlen", 32'(axi_arlen), 0);
        check("rst_dat_length", dat_length, 0);
        check("rst_outstanding", 32'(dut.outstanding), 0);
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // zero length: request consumed, nothing issued
        ar_addr_q.delete();
        start_cfg(32'h6000, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zl_cfg_ready", 32'(cfg_ready), 1);
            check("zl_dat_valid", 32'(dat_valid), 0);
            check("zl_arvalid", 32'(axi_arvalid), 0);
            tick();
        end

        // dat_ready and arready backpressure
        ar_addr_q.delete();
        ar_len_q.delete();
        axi_arready = 1'b0;
        start_cfg(32'h3000, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dh_dat_valid", 32'(dat_valid), 1);
            check("dh_dat_length", dat_length, 16);
            tick();
        end
        dat_ready = 1'b1;
        tick();
        dat_ready = 1'b0;
        for (int k = 0; k < 10 && !axi_arvalid; k++) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_arvalid", 32'(axi_arvalid), 1);
            check("bp_araddr", axi_araddr, 32'h3000);
            check("bp_arlen", 32'(axi_arlen), 7);
            tick();
        end
        check("bp_no_hs", ar_addr_q.size(), 0);
        axi_arready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("bp_hs_count", ar_addr_q.size(), 1);
        check("bp_cfg_ready", 32'(cfg_ready), 1);
        tick();

        // reset in ADDR after first burst, remaining 24
        ar_addr_q.delete();
        ar_len_q.delete();
        start_cfg(32'h4000, 40);
        dat_ready = 1'b1;
        tick();
        dat_ready = 1'b0;
        wait_bursts(1);
        check("mid_remaining", dut.remaining, 24);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_cfg_ready", 32'(cfg_ready), 1);
        check("mr_arvalid", 32'(axi_arvalid), 0);
        check("mr_dat_valid", 32'(dat_valid), 0);
        check("mr_outstanding", 32'(dut.outstanding), 0);
        check("mr_hs_count", ar_addr_q.size(), 1);
        tick();
        run_vec(mk(32'h5000, 8, 16, 1, 32'h5000, 7, 0, 0, 0, 0));

        // credit stall on the 32-beat buffer instance
        c_cfg_address = 32'h0;
        c_cfg_length  = 64;
        c_cfg_valid   = 1'b1;
        tick();
        c_cfg_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("cr_two_bursts", c_hs, 2);
        check("cr_stall", 32'(c_arvalid), 0);
        tick();
        c_rbeat = 1'b1;
        repeat (15) tick();
        c_rbeat = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("cr_15_still_stalled", c_hs, 2);
        check("cr_15_arvalid", 32'(c_arvalid), 0);
        tick();
        c_rbeat = 1'b1;
        tick();
        c_rbeat = 1'b0;
        for (int k = 0; k < 10 && c_hs < 3; k++) tick();
        check("cr_third", c_hs, 3);
        check("cr_third_addr", c_last_addr, 32'h100);
        check("cr_third_len", 32'(c_last_len), 15);
        repeat (5) tick();
        @(negedge clk);
        check("cr_third_stall", c_hs, 3);
        tick();
        c_rbeat = 1'b1;
        repeat (16) tick();
        c_rbeat = 1'b0;
        for (int k = 0; k < 10 && c_hs < 4; k++) tick();
        check("cr_fourth", c_hs, 4);
        check("cr_fourth_addr", c_last_addr, 32'h180);
        repeat (2) tick();
        @(negedge clk);
        check("cr_idle", 32'(c_cfg_ready), 1);
        check("cr_no_fifth", c_hs, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_read_burst_ctrl.md
Name: axis_read_burst_ctrl

Overview:
- Sequences one AXI read stream.
- Accepts a start address and a length in AXI beats.
- Hands the word count to the downstream read-data block (config handshake).
- Splits the transfer into AXI read-address bursts that never cross a 4 KB boundary.
- Throttles issue by outstanding-beat credit so the read-data buffer never overflows; axi_rready is never relied upon for flow control.

Parameters:
- BUF_AWIDTH, 9, log2 depth of the read-data buffer; credit limit CREDIT_MAX = 2**BUF_AWIDTH beats.
- CFG_DWIDTH, 32, width of configuration address/length fields.
- WIDTH_RATIO, 2, data words per AXI beat (AXI_DATA_WIDTH/DATA_WIDTH).
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width; BYTES = AXI_DATA_WIDTH/8.
- BURST_MAX, 16, maximum beats per burst (1..256, power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_address  in  CFG_DWIDTH  start byte address; low log2(BYTES) bits ignored.
- cfg_length  in  CFG_DWIDTH  transfer length in AXI beats.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  high in IDLE.
- dat_length  out  CFG_DWIDTH  word count for the read-data block = length*WIDTH_RATIO.
- dat_valid  out  1  data-block config request.
- dat_ready  in  1  data-block config accept.
- axi_araddr  out  AXI_ADDR_WIDTH  burst address.
- axi_arlen  out  8  beats-1.
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address accept.
- axi_rbeat  in  1  one read beat consumed from the AXI bus (rvalid & rready), returns one credit.

Behaviour:
- One-hot states: IDLE, START, ADDR.
- Reset: state IDLE; outstanding=0. Outputs: cfg_ready=1, dat_valid=0, axi_arvalid=0; axi_araddr, axi_arlen, dat_length=0. Reset mid-transfer abandons the remaining bursts immediately; no arvalid in the cycle after rst.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch addr = cfg_address with low bits cleared, and remaining = cfg_length.
  - If cfg_length==0, stay IDLE; the request is consumed, with no dat_valid and no AR.
  - Otherwise go to START.
- START:
  - dat_valid=1, dat_length = remaining*WIDTH_RATIO (truncated to CFG_DWIDTH).
  - Held stable until dat_ready; on dat_ready go to ADDR.
- ADDR:
  - burst = min(remaining, BURST_MAX, (4096 - addr[11:0])/BYTES).
  - The burst is computed registered, one cycle after entering ADDR or after each AR handshake. Bubble cycles are allowed; arvalid is low during them.
  - Assert axi_arvalid when outstanding + burst <= CREDIT_MAX.
  - axi_araddr = addr, axi_arlen = burst-1.
  - Once arvalid is high, araddr/arlen/arvalid are held stable until arready (AXI rule).
  - On handshake: addr += burst*BYTES, remaining -= burst, outstanding += burst.
  - If remaining becomes 0, go to IDLE in the next cycle.
- outstanding counter (BUF_AWIDTH+1 bits):
  - +burst on AR handshake, -1 on axi_rbeat; simultaneous events apply the net value.
  - Counting continues in IDLE, so the next transfer observes the credit still held.
  - axi_rbeat with outstanding==0 is a protocol error; the counter saturates at 0 (assertion in sim).
- The address wraps modulo 2**AXI_ADDR_WIDTH; no error is flagged.
- Latency: cfg accept -> dat_valid 1 cycle. dat handshake -> first arvalid 2 cycles when credit is available.

Decomposition:
- Shared package axis_pkg:
  - Constants AXI_4K_BYTES=4096 and AXI_LEN_WIDTH=8.
  - State index constants IDLE/START/ADDR.
  - A BYTES/ADDR_LSB derivation function.
- One natural sub-module, axis_burst_calc: registered min(remaining, BURST_MAX, beats-to-4K) computation. Its output is used by ADDR.
- Top pairs with the read-data block and the AXI port at system level.

Test Plan:
- Basic split, addr 0x1000, len 40, 64-bit, BURST_MAX 16 -> dat_length=80; AR bursts (0x1000, len 15), (0x1080, 15), (0x1100, 7); return to IDLE, cfg_ready=1.
- 4K crossing, addr 0x1FC0, len 16 -> bursts (0x1FC0, arlen 7) then (0x2000, arlen 7).
- Credit stall, BUF_AWIDTH=5, len 64, no rbeat -> two 16-beat bursts issued, then arvalid low. Pulse axi_rbeat 16 times -> third burst issues; fourth issues after 16 more.
- arready backpressure, arready low 5 cycles -> araddr/arlen/arvalid constant throughout; exactly one handshake counted.
- Zero length, cfg_valid with len 0 -> no dat_valid, no arvalid, cfg_ready stays 1. Unaligned addr 0x1004 is treated as 0x1000.
- Reset mid-burst, rst during ADDR with remaining 24 -> next cycle IDLE, arvalid=0, outstanding=0. A new cfg of len 8 runs normally.
